// File: rtl/mmu_bus_arbiter_pkg.sv
// Shared types for the MMU bus arbiter: FSM state encoding, source ids and the
// round-robin pick used when the bus is free.
package mmu_bus_pkg;

  // One-hot grant bits so the drive enables come straight off state flops.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    GNT_A = 3'b001,
    GNT_B = 3'b010,
    TURN  = 3'b100
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic state_t arb_pick(input logic req_a, input logic req_b, input logic rr_ptr);
    if (req_a && req_b) return (rr_ptr == SRC_B) ? GNT_B : GNT_A;
    else if (req_a)     return GNT_A;
    else if (req_b)     return GNT_B;
    else                return IDLE;
  endfunction

endpackage

// File: rtl/mmu_bus_arbiter_if.sv
// Handshake/bus-control bundle between the two bus sources, the arbiter and the
// bus register consumer.
interface mmu_bus_arbiter_if;
  logic req_a;
  logic req_b;
  logic out_ready;
  logic con_a;
  logic con_b;
  logic ack_a;
  logic ack_b;
  logic cap_en;
  logic out_valid;
  logic out_src;
  logic busy;

  modport master (
    input  req_a, req_b, out_ready,
    output con_a, con_b, ack_a, ack_b, cap_en, out_valid, out_src, busy
  );

  modport slave (
    output req_a, req_b, out_ready,
    input  con_a, con_b, ack_a, ack_b, cap_en, out_valid, out_src, busy
  );
endinterface

// File: rtl/mmu_bus_arbiter.sv
// Round-robin arbiter for the shared MMU tri-state bus: bounded bursts with a
// programmable dead time between drivers so the buffers never overlap.
module mmu_bus_arbiter
  import mmu_bus_pkg::*;
#(
  parameter  int unsigned MAX_BURST   = 4,
  parameter  int unsigned TURN_CYCLES = 1,
  localparam int unsigned CNT_W       = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  mmu_bus_arbiter_if.master  bus
);

  localparam int unsigned TURN_W = $clog2(TURN_CYCLES + 1);

  state_t              state;
  logic                rr_ptr;
  logic [CNT_W-1:0]    beat_cnt;
  logic [TURN_W-1:0]   turn_cnt;
  logic                beat_a;
  logic                beat_b;
  logic                req_cur;
  logic                last_beat;
  logic                leave;

  assign beat_a    = (state == GNT_A) && bus.req_a && bus.out_ready;
  assign beat_b    = (state == GNT_B) && bus.req_b && bus.out_ready;
  assign req_cur   = (state == GNT_A) ? bus.req_a : bus.req_b;
  assign last_beat = bus.out_ready && (beat_cnt == CNT_W'(MAX_BURST - 1));
  // A withdrawn request releases the grant even mid-stall; no beat is taken.
  assign leave     = !req_cur || last_beat;

  assign bus.con_a  = state[0];
  assign bus.con_b  = state[1];
  assign bus.busy   = (state != IDLE);
  assign bus.ack_a  = beat_a;
  assign bus.ack_b  = beat_b;
  assign bus.cap_en = beat_a || beat_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= SRC_A;
      beat_cnt      <= '0;
      turn_cnt      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_src   <= 1'b0;
    end else begin
      bus.out_valid <= beat_a || beat_b;
      bus.out_src   <= (state == GNT_B);
      unique case (state)
        IDLE: state <= arb_pick(bus.req_a, bus.req_b, rr_ptr);
        GNT_A, GNT_B: begin
          if (leave) begin
            state    <= TURN;
            rr_ptr   <= (state == GNT_A) ? SRC_B : SRC_A;
            beat_cnt <= '0;
            turn_cnt <= '0;
          end else if (bus.out_ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        TURN: begin
          // Arbitrate straight out of the dead time, skipping IDLE.
          if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) begin
            state    <= arb_pick(bus.req_a, bus.req_b, rr_ptr);
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.con_a && bus.con_b));
  a_cap_one_con: assert property (@(posedge clk) disable iff (!rst_n)
    bus.cap_en |-> (bus.con_a ^ bus.con_b));

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Directed bench for mmu_bus_arbiter: per-cycle expected enables/acks plus a
// queue of expected beat sources checked against out_valid/out_src.
module tb_mmu_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmu_bus_arbiter_if if0();
  mmu_bus_arbiter_if if1();

  mmu_bus_arbiter #(.MAX_BURST(4), .TURN_CYCLES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mmu_bus_arbiter #(.MAX_BURST(1), .TURN_CYCLES(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        exp_q[$];
  logic        prev_cap = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic ra, input logic rb, input logic rdy);
    if0.req_a = (d == 0) ? ra : 1'b0;
    if0.req_b = (d == 0) ? rb : 1'b0;
    if0.out_ready = (d == 0) ? rdy : 1'b0;
    if1.req_a = (d == 1) ? ra : 1'b0;
    if1.req_b = (d == 1) ? rb : 1'b0;
    if1.out_ready = (d == 1) ? rdy : 1'b0;
  endtask

  // One bus cycle: ea/eb = expected grant side, k = expected beat this cycle.
  task automatic cyc(input int d, input logic ra, input logic rb, input logic rdy,
                     input logic ea, input logic eb, input logic k);
    logic oca, ocb, oaa, oab, ocap, obusy, oov, osrc;
    @(negedge clk);
    drive(d, ra, rb, rdy);
    #1;
    oca   = (d == 0) ? if0.con_a     : if1.con_a;
    ocb   = (d == 0) ? if0.con_b     : if1.con_b;
    oaa   = (d == 0) ? if0.ack_a     : if1.ack_a;
    oab   = (d == 0) ? if0.ack_b     : if1.ack_b;
    ocap  = (d == 0) ? if0.cap_en    : if1.cap_en;
    obusy = (d == 0) ? if0.busy      : if1.busy;
    oov   = (d == 0) ? if0.out_valid : if1.out_valid;
    osrc  = (d == 0) ? if0.out_src   : if1.out_src;
    chk($sformatf("d%0d con_a", d), oca, ea);
    chk($sformatf("d%0d con_b", d), ocb, eb);
    chk($sformatf("d%0d ack_a", d), oaa, ea & k);
    chk($sformatf("d%0d ack_b", d), oab, eb & k);
    chk($sformatf("d%0d cap_en", d), ocap, k);
    if (ea || eb) chk($sformatf("d%0d busy", d), obusy, 1'b1);
    chk($sformatf("d%0d out_valid", d), oov, prev_cap);
    if (oov) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL d%0d out_src: got beat src %b expected no pending beat", d, osrc);
      end
      if (exp_q.size() > 0) chk($sformatf("d%0d out_src", d), osrc, exp_q.pop_front());
    end
    if (k) exp_q.push_back(eb);
    prev_cap = k;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst d0 con_a", if0.con_a, 1'b0);
    chk("rst d0 con_b", if0.con_b, 1'b0);
    chk("rst d0 busy", if0.busy, 1'b0);
    chk("rst d0 out_valid", if0.out_valid, 1'b0);
    chk("rst d0 out_src", if0.out_src, 1'b0);
    chk("rst d1 busy", if1.busy, 1'b0);
    rst_n = 1'b1;

    // Sole requester A: 4 beats on, 1 turnaround off, re-granted.
    for (int i = 0; i <= 10; i++) begin
      logic on;
      on = ((i % 5) != 0);
      cyc(0, 1'b1, 1'b0, 1'b1, on, 1'b0, on);
    end
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // withdraw with zero beats
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset in the middle of an A burst.
    cyc(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst con_a", if0.con_a, 1'b0);
    chk("midrst cap_en", if0.cap_en, 1'b0);
    chk("midrst ack_a", if0.ack_a, 1'b0);
    chk("midrst busy", if0.busy, 1'b0);
    chk("midrst out_valid", if0.out_valid, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    prev_cap = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Both held from reset: A(4) TURN B(4) TURN A(4).
    for (int i = 0; i <= 14; i++) begin
      logic on, side;
      on   = (i != 0) && (((i - 1) % 5) != 4);
      side = (i != 0) && ((((i - 1) / 5) % 2) == 1);
      cyc(0, 1'b1, 1'b1, 1'b1, on & ~side, on & side, on);
    end
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // B burst stalled 3 cycles after its 2nd beat, still totals 4 beats.
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // A withdraws (while stalled) after 2 beats; B waiting takes over.
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // rr_ptr back on A
    cyc(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // MAX_BURST=1, TURN_CYCLES=3: A, 3 idle, B, 3 idle, ...
    for (int i = 0; i <= 15; i++) begin
      logic on, side;
      on   = (i != 0) && (((i - 1) % 4) == 0);
      side = (i != 0) && ((((i - 1) / 4) % 2) == 1);
      cyc(1, 1'b1, 1'b1, 1'b1, on & ~side, on & side, on);
    end
    cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("end d1 busy", if1.busy, 1'b0);
    chk("end d0 busy", if0.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
